// File: rtl/decode_issue_arbiter_if.sv
// decode_issue_arbiter_if
// Bundles the fetch-buffer request side and the decode-unit side of the
// decode issue arbiter.
//   master : the arbiter (consumes requests/stall/flush, drives grant and payload)
//   slave  : the surrounding fetch buffers and decode unit
// Per-thread request fields are packed, thread n at slice n.
interface decode_issue_arbiter_if #(
    parameter int unsigned numThreads              = 4,
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned instructionWidth        = 32,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64
);
    localparam int unsigned threadIdxWidth = (numThreads > 1) ? $clog2(numThreads) : 1;

    // Request side
    logic [numThreads-1:0]                  reqValid_i;
    logic [numThreads*instructionWidth-1:0] reqInstruction_i;
    logic [numThreads*addressWidth-1:0]     reqAddress_i;
    logic [numThreads-1:0]                  reqIs64Bit_i;
    logic [numThreads*PidSize-1:0]          reqPid_i;
    logic [numThreads*TidSize-1:0]          reqTid_i;
    logic [numThreads-1:0]                  grant_o;

    // Decode side
    logic                                   stall_i;
    logic                                   flush_i;
    logic [threadIdxWidth-1:0]              flushThread_i;
    logic                                   enable_o;
    logic [instructionWidth-1:0]            instruction_o;
    logic [addressWidth-1:0]                instructionAddress_o;
    logic                                   is64Bit_o;
    logic [PidSize-1:0]                     instructionPid_o;
    logic [TidSize-1:0]                     instructionTid_o;
    logic [instructionCounterWidth-1:0]     instructionMajId_o;
    logic [threadIdxWidth-1:0]              threadId_o;

    modport master (
        input  reqValid_i, reqInstruction_i, reqAddress_i, reqIs64Bit_i, reqPid_i, reqTid_i,
        input  stall_i, flush_i, flushThread_i,
        output grant_o, enable_o, instruction_o, instructionAddress_o, is64Bit_o,
        output instructionPid_o, instructionTid_o, instructionMajId_o, threadId_o
    );

    modport slave (
        output reqValid_i, reqInstruction_i, reqAddress_i, reqIs64Bit_i, reqPid_i, reqTid_i,
        output stall_i, flush_i, flushThread_i,
        input  grant_o, enable_o, instruction_o, instructionAddress_o, is64Bit_o,
        input  instructionPid_o, instructionTid_o, instructionMajId_o, threadId_o
    );
endinterface

// File: rtl/decode_issue_arbiter.sv
// decode_issue_arbiter
// Round-robin arbiter that picks one hardware-thread fetch buffer per cycle and
// registers its instruction payload (tagged with a running major ID) for decode.
// Ports:
//   clock_i  : clock, all state on the rising edge
//   reset_i  : asynchronous active-low reset
//   issueBus : decode_issue_arbiter_if.master
//              requests (valid/instruction/address/mode/PID/TID per thread), stall,
//              flush + flushThread in; one-hot combinational grant, enable and the
//              registered payload (instruction, address, mode, PID, TID, major ID,
//              owning thread) out.
module decode_issue_arbiter #(
    parameter int unsigned numThreads              = 4,
    parameter int unsigned addressWidth            = 64,
    parameter int unsigned instructionWidth        = 32,
    parameter int unsigned PidSize                 = 20,
    parameter int unsigned TidSize                 = 16,
    parameter int unsigned instructionCounterWidth = 64
) (
    input logic                    clock_i,
    input logic                    reset_i,
    decode_issue_arbiter_if.master issueBus
);
    localparam int unsigned threadIdxWidth = (numThreads > 1) ? $clog2(numThreads) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StHold} stateT;

    stateT                              stateQ, stateD;
    logic [threadIdxWidth-1:0]          rrPtrQ;
    logic [instructionCounterWidth-1:0] majCtrQ;

    logic [instructionWidth-1:0]        instructionQ;
    logic [addressWidth-1:0]            addressQ;
    logic                               is64BitQ;
    logic [PidSize-1:0]                 pidQ;
    logic [TidSize-1:0]                 tidQ;
    logic [instructionCounterWidth-1:0] majIdQ;
    logic [threadIdxWidth-1:0]          threadIdQ;

    logic [numThreads-1:0]              eligible;
    logic [numThreads-1:0]              grant;
    logic                               grantValid;
    logic [threadIdxWidth-1:0]          grantIdx;
    logic                               flushHit;

    // Grant selection. Reset is folded in so grant stays low while reset is held.
    always_comb begin
        eligible   = '0;
        grant      = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int unsigned n = 0; n < numThreads; n++) begin
            eligible[n] = reset_i && !issueBus.stall_i && issueBus.reqValid_i[n] &&
                          !(issueBus.flush_i &&
                            (issueBus.flushThread_i == threadIdxWidth'(n)));
        end
        // Search order starts at rrPtrQ and wraps, so the last winner goes to the back.
        for (int unsigned k = 0; k < numThreads; k++) begin
            int unsigned               sum;
            logic [threadIdxWidth-1:0] idx;
            sum = 32'(rrPtrQ) + k;
            if (sum >= numThreads) begin
                sum = sum - numThreads;
            end
            idx = threadIdxWidth'(sum);
            if (!grantValid && eligible[idx]) begin
                grantValid  = 1'b1;
                grantIdx    = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    // A flush only kills the payload currently presented to decode.
    assign flushHit = issueBus.flush_i && (stateQ != StIdle) &&
                      (threadIdQ == issueBus.flushThread_i);

    // State register
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic. A grant is impossible under stall, so stall only chooses
    // between holding and dropping the current payload.
    always_comb begin
        stateD = stateQ;
        if (grantValid) begin
            stateD = StIssue;
        end else if (issueBus.stall_i) begin
            if (flushHit || (stateQ == StIdle)) begin
                stateD = StIdle;
            end else begin
                stateD = StHold;
            end
        end else begin
            stateD = StIdle;
        end
    end

    // Outputs
    always_comb begin
        issueBus.enable_o             = (stateQ != StIdle);
        issueBus.grant_o              = grant;
        issueBus.instruction_o        = instructionQ;
        issueBus.instructionAddress_o = addressQ;
        issueBus.is64Bit_o            = is64BitQ;
        issueBus.instructionPid_o     = pidQ;
        issueBus.instructionTid_o     = tidQ;
        issueBus.instructionMajId_o   = majIdQ;
        issueBus.threadId_o           = threadIdQ;
    end

    // Payload, round-robin pointer and major counter only move on a grant; the
    // payload is otherwise retained (qualified downstream by enable_o).
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rrPtrQ       <= '0;
            majCtrQ      <= '0;
            instructionQ <= '0;
            addressQ     <= '0;
            is64BitQ     <= 1'b0;
            pidQ         <= '0;
            tidQ         <= '0;
            majIdQ       <= '0;
            threadIdQ    <= '0;
        end else if (grantValid) begin
            instructionQ <= issueBus.reqInstruction_i[grantIdx*instructionWidth +: instructionWidth];
            addressQ     <= issueBus.reqAddress_i[grantIdx*addressWidth +: addressWidth];
            is64BitQ     <= issueBus.reqIs64Bit_i[grantIdx];
            pidQ         <= issueBus.reqPid_i[grantIdx*PidSize +: PidSize];
            tidQ         <= issueBus.reqTid_i[grantIdx*TidSize +: TidSize];
            majIdQ       <= majCtrQ;
            threadIdQ    <= grantIdx;
            majCtrQ      <= majCtrQ + 1'b1;
            rrPtrQ       <= (32'(grantIdx) + 1 >= numThreads) ? '0 : grantIdx + 1'b1;
        end
    end
endmodule
